prog_loader: RTL and testbench

- Writer-side counterpart of the CPU instruction fetch path. Streams a program image into the instruction RAM through its write port.
- Reads the image back through the RAM read port and checks it against a sum computed during the load.
- Releases the CPU from reset only after the readback check passes.
- Sits between a byte-stream source (host, bench, or a future UART receiver) and the `ram`/`cpu` pair.

---
 rtl/prog_loader_pkg.sv | 25 ++
 rtl/prog_loader_if.sv | 41 ++++
 rtl/prog_loader_sum.sv | 33 +++
 rtl/prog_loader.sv | 157 +++++++++++++++
 tb/tb_prog_loader.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_pkg
//  Description : Shared types and constants for the program loader.
//  Revision    : 1.0  initial release
// ============================================================================
package prog_loader_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_SUM  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_if
//  Description : Stream, RAM and CPU-control signals around the loader.
//  Revision    : 1.0  initial release
// ============================================================================
interface prog_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              start;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    // Environment side: byte source, RAM read data, status consumer.
    modport master (
        output start, s_valid, s_data, s_last, ram_rdata,
        input  s_ready, ram_we, ram_waddr, ram_wdata, ram_raddr,
        input  cpu_reset, busy, done, err, err_code
    );

    // Loader side.
    modport slave (
        input  start, s_valid, s_data, s_last, ram_rdata,
        output s_ready, ram_we, ram_waddr, ram_wdata, ram_raddr,
        output cpu_reset, busy, done, err, err_code
    );
endinterface
`default_nettype wire

// File: rtl/prog_loader_sum.sv
`default_nettype none
// ============================================================================
//  Module      : prog_sum
//  Description : Modular accumulator with synchronous clear and enable.
//  Revision    : 1.0  initial release
// ============================================================================
module prog_sum
    import prog_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              clr_i,
    input  wire logic              en_i,
    input  wire logic [DATA_W-1:0] din_i,
    output logic      [DATA_W-1:0] sum_o
);

    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            sum_q <= '0;
        end else if (en_i) begin
            sum_q <= sum_q + din_i;
        end
    end

    assign sum_o = sum_q;

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Streams an image into instruction RAM, verifies it by
//                readback checksum and then releases the CPU from reset.
//  Revision    : 1.0  initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic   clk,
    input  wire logic   reset,
    prog_loader_if.slave bus
);

    localparam logic [ADDR_W-1:0] c_ptr_one = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_len_one = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q;
    logic [ADDR_W-1:0] wptr_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   rcnt_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_waddr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic [ADDR_W-1:0] ram_raddr_q;
    logic              cpu_reset_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [1:0]        err_code_q;

    logic              w_accept;
    logic              w_start_load;
    logic              w_verify_start;
    logic              w_verify_en;
    logic [ADDR_W:0]   w_rcnt_nxt;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_rsum;
    logic [DATA_W-1:0] w_rsum_fin;

    assign w_accept       = bus.s_valid && (state_q == ST_LOAD);
    assign w_start_load   = bus.start && ((state_q == ST_IDLE) || (state_q == ST_RUN) ||
                                          (state_q == ST_FAIL));
    assign w_verify_start = w_accept && bus.s_last;
    // Read data trails the address by one cycle, so the first VERIFY cycle has nothing to add.
    assign w_verify_en    = (state_q == ST_VERIFY) && (rcnt_q != '0);
    assign w_rcnt_nxt     = rcnt_q + c_len_one;
    assign w_rsum_fin     = w_rsum + bus.ram_rdata;

    prog_sum #(.DATA_W(DATA_W)) u_load_sum (
        .clk   (clk),
        .reset (reset),
        .clr_i (w_start_load),
        .en_i  (w_accept),
        .din_i (bus.s_data),
        .sum_o (w_sum)
    );

    prog_sum #(.DATA_W(DATA_W)) u_read_sum (
        .clk   (clk),
        .reset (reset),
        .clr_i (w_verify_start),
        .en_i  (w_verify_en),
        .din_i (bus.ram_rdata),
        .sum_o (w_rsum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wptr_q      <= '0;
            len_q       <= '0;
            rcnt_q      <= '0;
            ram_we_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
            ram_raddr_q <= '0;
            cpu_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            ram_we_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_RUN, ST_FAIL: begin
                    if (bus.start) begin
                        state_q     <= ST_LOAD;
                        wptr_q      <= '0;
                        ram_raddr_q <= '0;
                        cpu_reset_q <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                        err_code_q  <= ERR_NONE;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        ram_we_q    <= 1'b1;
                        ram_waddr_q <= wptr_q;
                        ram_wdata_q <= bus.s_data;
                        wptr_q      <= wptr_q + c_ptr_one;
                        if (bus.s_last) begin
                            state_q     <= ST_VERIFY;
                            len_q       <= {1'b0, wptr_q} + c_len_one;
                            rcnt_q      <= '0;
                            ram_raddr_q <= '0;
                        end else if (wptr_q == '1) begin
                            state_q    <= ST_FAIL;
                            busy_q     <= 1'b0;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_OVF;
                        end
                    end
                end
                ST_VERIFY: begin
                    // With len=1 the single read collides with the final write; the RAM
                    // must return the newly written word on a same-address collision.
                    rcnt_q      <= w_rcnt_nxt;
                    ram_raddr_q <= (w_rcnt_nxt < len_q) ? w_rcnt_nxt[ADDR_W-1:0] : '0;
                    if (rcnt_q == len_q) begin
                        busy_q      <= 1'b0;
                        ram_raddr_q <= '0;
                        if (w_rsum_fin == w_sum) begin
                            state_q     <= ST_RUN;
                            done_q      <= 1'b1;
                            cpu_reset_q <= 1'b1;
                        end else begin
                            state_q    <= ST_FAIL;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_SUM;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_ready   = (state_q == ST_LOAD);
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_waddr = ram_waddr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_raddr = ram_raddr_q;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Directed self-checking bench for prog_loader with a RAM model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prog_loader;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    logic [7:0]  mem [16];
    logic [11:0] wlog [$];

    prog_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first synchronous RAM: a same-address write is visible to the read.
    always @(posedge clk) begin
        bus.ram_rdata <= (bus.ram_we && (bus.ram_waddr == bus.ram_raddr)) ?
                         bus.ram_wdata : mem[bus.ram_raddr];
        if (bus.ram_we) begin
            mem[bus.ram_waddr] = bus.ram_wdata;
            wlog.push_back({bus.ram_waddr, bus.ram_wdata});
        end
    end

    function automatic logic [23:0] out_vec();
        return {bus.s_ready, bus.ram_we, bus.ram_waddr, bus.ram_wdata, bus.ram_raddr,
                bus.cpu_reset, bus.busy, bus.done, bus.err, bus.err_code};
    endfunction

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_verify(output int vcyc, output bit timeout);
        vcyc    = 0;
        timeout = 1'b1;
        for (int n = 0; n < 64; n++) begin
            if (!bus.busy) begin
                timeout = 1'b0;
                break;
            end
            if (!bus.s_ready) vcyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (out_vec() !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", out_vec(), 24'h0);
        end
    endtask

    task automatic test_load4();
        logic [7:0] img [4];
        int  vcyc;
        bit  to;
        int  bad;
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        wlog.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(img[i], i == 3);
        wait_verify(vcyc, to);
        checks++;
        if (to) begin errors++; $display("FAIL load4_timeout: busy never dropped"); end
        checks++;
        if (vcyc !== 5) begin errors++; $display("FAIL load4_verify_len: got %0d expected 5", vcyc); end
        checks++;
        if ({bus.done, bus.cpu_reset, bus.err} !== 3'b110) begin
            errors++;
            $display("FAIL load4_status: got %b expected 110", {bus.done, bus.cpu_reset, bus.err});
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (wlog.size() <= i || wlog[i] !== {i[3:0], img[i]}) bad++;
            if (mem[i] !== img[i]) bad++;
        end
        checks++;
        if (wlog.size() !== 4 || bad != 0) begin
            errors++;
            $display("FAIL load4_writes: got %0d writes %0d bad expected 4 writes 0 bad", wlog.size(), bad);
        end
        checks++;
        if (bus.ram_raddr !== 4'h0) begin
            errors++;
            $display("FAIL load4_raddr_run: got %h expected 0", bus.ram_raddr);
        end
    endtask

    task automatic test_full16_gapped();
        int vcyc;
        bit to;
        int bad;
        wlog.delete();
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), i == 15);
            if (i != 15) @(negedge clk);
        end
        wait_verify(vcyc, to);
        checks++;
        if (to || vcyc !== 17) begin
            errors++;
            $display("FAIL full16_verify_len: got %0d timeout=%0d expected 17", vcyc, to);
        end
        checks++;
        if (dut.w_sum !== 8'h78) begin
            errors++;
            $display("FAIL full16_sum: got %h expected 78", dut.w_sum);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (wlog.size() <= i || wlog[i] !== {i[3:0], i[7:0]}) bad++;
        end
        checks++;
        if (wlog.size() !== 16 || bad != 0) begin
            errors++;
            $display("FAIL full16_writes: got %0d writes %0d bad expected 16 writes 0 bad", wlog.size(), bad);
        end
        checks++;
        if ({bus.done, bus.cpu_reset} !== 2'b11) begin
            errors++;
            $display("FAIL full16_run: got %b expected 11", {bus.done, bus.cpu_reset});
        end
    endtask

    task automatic test_overflow();
        wlog.delete();
        pulse_start();
        for (int i = 0; i < 15; i++) send_byte(8'hA0 + 8'(i), 1'b0);
        checks++;
        if ({bus.err, bus.s_ready} !== 2'b01) begin
            errors++;
            $display("FAIL ovf_before_16: got err,s_ready=%b expected 01", {bus.err, bus.s_ready});
        end
        send_byte(8'hAF, 1'b0);
        checks++;
        if ({bus.err, bus.err_code, bus.cpu_reset, bus.s_ready, bus.busy} !== 6'b101000) begin
            errors++;
            $display("FAIL ovf_state: got %b expected 101000",
                     {bus.err, bus.err_code, bus.cpu_reset, bus.s_ready, bus.busy});
        end
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hBB;
        repeat (3) @(negedge clk);
        bus.s_valid = 1'b0;
        checks++;
        if (wlog.size() !== 16) begin
            errors++;
            $display("FAIL ovf_17th_dropped: got %0d writes expected 16", wlog.size());
        end
    endtask

    task automatic test_sum_mismatch();
        int vcyc;
        bit to;
        pulse_start();
        send_byte(8'hAA, 1'b0);
        send_byte(8'h55, 1'b1);
        @(negedge clk);
        mem[1] = 8'h54;
        wait_verify(vcyc, to);
        checks++;
        if (to || {bus.err, bus.err_code, bus.done, bus.cpu_reset} !== 5'b11000) begin
            errors++;
            $display("FAIL sum_mismatch: got %b timeout=%0d expected 11000",
                     {bus.err, bus.err_code, bus.done, bus.cpu_reset}, to);
        end
    endtask

    task automatic test_reload_from_run();
        int vcyc;
        bit to;
        pulse_start();
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b1);
        wait_verify(vcyc, to);
        checks++;
        if (to || {bus.done, bus.cpu_reset, bus.err} !== 3'b110) begin
            errors++;
            $display("FAIL reload_first_run: got %b expected 110", {bus.done, bus.cpu_reset, bus.err});
        end
        pulse_start();
        checks++;
        if ({bus.s_ready, bus.cpu_reset, bus.done, bus.busy} !== 4'b1001) begin
            errors++;
            $display("FAIL reload_load_entry: got %b expected 1001",
                     {bus.s_ready, bus.cpu_reset, bus.done, bus.busy});
        end
        send_byte(8'h01, 1'b1);
        wait_verify(vcyc, to);
        checks++;
        if (to || vcyc !== 2 || {bus.done, bus.cpu_reset} !== 2'b11 || mem[0] !== 8'h01) begin
            errors++;
            $display("FAIL reload_run: got vcyc=%0d done,cpu=%b mem0=%h expected 2 11 01",
                     vcyc, {bus.done, bus.cpu_reset}, mem[0]);
        end
    endtask

    task automatic test_reset_mid_load();
        int vcyc;
        bit to;
        int bad;
        wlog.delete();
        pulse_start();
        send_byte(8'h77, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h66;
        reset       = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        bus.s_valid = 1'b0;
        checks++;
        if (out_vec() !== 24'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected %h", out_vec(), 24'h0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wlog.size() !== 1) begin
            errors++;
            $display("FAIL midreset_writes: got %0d writes expected 1", wlog.size());
        end
        pulse_start();
        for (int i = 0; i < 16; i++) send_byte(8'hF0 ^ 8'(i * 3), i == 15);
        wait_verify(vcyc, to);
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== (8'hF0 ^ 8'(i * 3))) bad++;
        checks++;
        if (to || vcyc !== 17 || {bus.done, bus.cpu_reset, bus.err} !== 3'b110 || bad != 0) begin
            errors++;
            $display("FAIL midreset_reload: got vcyc=%0d status=%b bad=%0d expected 17 110 0",
                     vcyc, {bus.done, bus.cpu_reset, bus.err}, bad);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        @(negedge clk);
        test_reset();
        test_load4();
        test_full16_gapped();
        test_overflow();
        test_sum_mismatch();
        test_reload_from_run();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
